pwm_wb_channels: RTL
====================

// Module: pwm_wb_channels
// PURPOSE
//   Wishbone-slave PWM generator inside the user project area, directly upstream of the mprj_io pads.
//   Holds a register file for NUM_CH PWM channels and runs one period/duty counter per channel.
//   Drives the channel outputs and their active-low output enables to the pads.
//   Firmware reaches it through the management SoC Wishbone bus.
// PARAMETERS
//   NUM_CH     4             number of PWM channels (1..8)
//   CNT_W      16            counter/period/duty width in bits (<=32)
//   BASE_ADDR  32'h3000_0000 Wishbone base address; decode window is BASE_ADDR[31:8]
// PORTS
//   wb_clk_i   in  1       single clock; all logic on posedge
//   wb_rst_i   in  1       reset; synchronous, active-high
//   wbs_cyc_i  in  1       Wishbone cycle
//   wbs_stb_i  in  1       Wishbone strobe
//   wbs_we_i   in  1       write enable
//   wbs_sel_i  in  4       byte lane selects
//   wbs_adr_i  in  32      byte address
//   wbs_dat_i  in  32      write data
//   wbs_ack_o  out 1       acknowledge
//   wbs_dat_o  out 32      read data
//   pwm_o      out NUM_CH  PWM waveforms to mprj_io
//   io_oeb     out NUM_CH  pad output enables, active-low
//   irq        out 3       user interrupts; only irq[0] is used
// BEHAVIOUR
//   Reset: all registers, counters and shadows = 0; wbs_ack_o=0; wbs_dat_o=0; pwm_o=0; io_oeb=all 1; irq=0.
//   Bus access: an access is valid when cyc&stb and adr[31:8]==BASE_ADDR[31:8].
//   - Ack is a 1-cycle pulse one clock after the access is valid, and is never asserted on two consecutive cycles.
//   - Write takes effect at the ack edge, byte-masked by wbs_sel_i.
//   - wbs_dat_o is valid with ack and is 0 otherwise.
//   - Outside the window: no ack, no side effects.
//   - Unmapped offset inside the window: ack, read 0, write ignored.
//   Map (offset): 0x00 CTRL[NUM_CH-1:0] enable; 0x04 STATUS (W1C); 0x08 IRQ_MASK;
//                 0x10+8*n PERIOD_n[CNT_W-1:0]; 0x14+8*n DUTY_n[CNT_W-1:0].
//   Channel n disabled: cnt=0; pwm_o[n]=0; io_oeb[n]=1; shadows copy PERIOD/DUTY every cycle.
//   Channel n enabled:
//   - io_oeb[n]=0.
//   - cnt counts 0..per_s, then wraps to 0, giving a cycle length of per_s+1 clocks.
//   - pwm_o[n] is registered: (cnt<duty_s)&&(per_s!=0).
//   - At the wrap edge, per_s/duty_s reload from PERIOD/DUTY, so a mid-period write is glitch-free.
//   Boundaries:
//   - per_s==0: output held low, cnt stays 0, a wrap occurs every cycle.
//   - duty_s==0: constant low.
//   - duty_s>per_s: constant high.
//   - CTRL 1->0: channel is disabled on the next cycle and cnt is cleared.
//   - Write to PERIOD at the same edge as a wrap: the new value is loaded.
//   - wb_rst_i during a bus cycle: ack dropped, write lost.
// CONFIGURATION
//   PWM_IRQ_EN defined:
//   - Each wrap of an enabled channel sets STATUS[n].
//   - A W1C to a bit at the same edge as its set: set wins.
//   - irq[0] = |(STATUS & IRQ_MASK), registered.
//   - irq[2:1] = 0.
//   PWM_IRQ_EN undefined: STATUS and IRQ_MASK read 0 and ignore writes; irq = 3'b000. Ports are unchanged.
// STRUCTURE
//   Shared package pwm_pkg: register offset localparams, CTRL/STATUS field widths, MAX_CH=8.
//   Sub-module pwm_channel (cnt, per_s/duty_s shadows, compare, wrap pulse), instantiated NUM_CH times.
//   The top level holds the bus decode and the register file.
// TESTING
//   1. Reset, then read 0x00/0x10/0x14 -> all 0, ack 1 cycle after stb; io_oeb=4'hF, pwm_o=0.
//   2. PERIOD_0=9, DUTY_0=3, CTRL=1 -> pwm_o[0] high 3 clocks, low 7 clocks, repeating every 10 clocks; io_oeb[0]=0.
//   3. During a period write DUTY_0=7 -> current period keeps 3 high; from the next wrap, 7 high/3 low.
//   4. DUTY_1=0 -> constant low; DUTY_1=20 with PERIOD_1=9 -> constant high; PERIOD_1=0 -> low.
//   5. Access at adr 0x3000_0100 -> no ack; sel=4'b0001 write 0xFFFF to PERIOD_2 -> reads back 0x00FF.
//   6. (PWM_IRQ_EN) IRQ_MASK=1, ch0 enabled -> irq[0]=1 after the first wrap; W1C STATUS=1 -> irq[0] low, re-set on the next wrap.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the Wishbone PWM block: register offsets, field
// widths and the byte-lane merge used by every writable register.
package pwm_pkg;

    localparam int MAX_CH   = 8;
    localparam int CTRL_W   = MAX_CH;
    localparam int STATUS_W = MAX_CH;

    // Byte offsets inside the 256-byte decode window
    localparam logic [7:0] OFS_CTRL      = 8'h00;
    localparam logic [7:0] OFS_STATUS    = 8'h04;
    localparam logic [7:0] OFS_IRQ_MASK  = 8'h08;
    localparam logic [7:0] OFS_PERIOD0   = 8'h10;
    localparam logic [7:0] OFS_DUTY0     = 8'h14;
    localparam int         OFS_CH_STRIDE = 8;

    // Replace only the byte lanes selected by sel
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/pwm_wb_channels_channel.sv
// One PWM channel: free-running period counter with shadowed period/duty.
// Shadows reload only at the wrap so register writes never cut a period short.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] duty,
    output logic             pwm,
    output logic             oeb,
    output logic             wrap
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] per_s_q;
    logic [CNT_W-1:0] duty_s_q;
    logic             pwm_q;

    assign wrap = en & (cnt_q == per_s_q);
    assign pwm  = pwm_q;
    assign oeb  = ~en;

    // Counter, shadow reload and registered compare
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            per_s_q  <= '0;
            duty_s_q <= '0;
            pwm_q    <= 1'b0;
        end else if (!en) begin
            cnt_q    <= '0;
            per_s_q  <= period;
            duty_s_q <= duty;
            pwm_q    <= 1'b0;
        end else begin
            pwm_q <= (cnt_q < duty_s_q) && (per_s_q != '0);
            if (wrap) begin
                cnt_q    <= '0;
                per_s_q  <= period;
                duty_s_q <= duty;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_wb_channels.sv
// Wishbone slave PWM generator: bus decode, register file and NUM_CH
// pwm_channel instances driving the pads.
// Optional feature macro: PWM_IRQ_EN (wrap status bits and irq[0]).
module pwm_wb_channels
    import pwm_pkg::*;
#(
    parameter int          NUM_CH    = 4,
    parameter int          CNT_W     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic [NUM_CH-1:0] pwm_o,
    output logic [NUM_CH-1:0] io_oeb,
    output logic [2:0]        irq
);

    logic              ack_q;
    logic [31:0]       dat_q;
    logic              irq_q;
    logic              hit;
    logic              acc;
    logic              wr;
    logic [7:0]        ofs;
    logic [31:0]       rdata;
    logic [NUM_CH-1:0] ctrl_q, ctrl_d;
    logic [NUM_CH-1:0] status_q, status_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [NUM_CH-1:0] wrap;
    logic [CNT_W-1:0]  per_q  [NUM_CH];
    logic [CNT_W-1:0]  per_d  [NUM_CH];
    logic [CNT_W-1:0]  duty_q [NUM_CH];
    logic [CNT_W-1:0]  duty_d [NUM_CH];

    // acc is the single cycle in which an access is acknowledged and committed
    assign ofs = wbs_adr_i[7:0];
    assign hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign acc = hit & ~ack_q;
    assign wr  = acc & wbs_we_i;

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq       = {2'b00, irq_q};

    // Register-file next values; channels see these so a write on a wrap edge is taken
    always_comb begin
        ctrl_d   = ctrl_q;
        status_d = status_q;
        mask_d   = mask_q;
        for (int n = 0; n < NUM_CH; n++) begin
            per_d[n]  = per_q[n];
            duty_d[n] = duty_q[n];
        end
        if (wr && ofs == OFS_CTRL)
            ctrl_d = NUM_CH'(byte_merge(32'(ctrl_q), wbs_dat_i, wbs_sel_i));
        for (int n = 0; n < NUM_CH; n++) begin
            if (wr && ofs == 8'(int'(OFS_PERIOD0) + OFS_CH_STRIDE*n))
                per_d[n] = CNT_W'(byte_merge(32'(per_q[n]), wbs_dat_i, wbs_sel_i));
            if (wr && ofs == 8'(int'(OFS_DUTY0) + OFS_CH_STRIDE*n))
                duty_d[n] = CNT_W'(byte_merge(32'(duty_q[n]), wbs_dat_i, wbs_sel_i));
        end
`ifdef PWM_IRQ_EN
        if (wr && ofs == OFS_IRQ_MASK)
            mask_d = NUM_CH'(byte_merge(32'(mask_q), wbs_dat_i, wbs_sel_i));
        if (wr && ofs == OFS_STATUS)
            status_d = status_q & ~NUM_CH'(byte_merge(32'h0, wbs_dat_i, wbs_sel_i));
        // a wrap on the same edge as the clear keeps the bit set
        status_d = status_d | wrap;
`else
        status_d = '0;
        mask_d   = '0;
`endif
    end

`ifndef PWM_IRQ_EN
    logic unused_wrap;
    assign unused_wrap = ^wrap;
`endif

    // Read mux; unmapped offsets read as zero
    always_comb begin
        rdata = '0;
        if (ofs == OFS_CTRL)     rdata = 32'(ctrl_q);
        if (ofs == OFS_STATUS)   rdata = 32'(status_q);
        if (ofs == OFS_IRQ_MASK) rdata = 32'(mask_q);
        for (int n = 0; n < NUM_CH; n++) begin
            if (ofs == 8'(int'(OFS_PERIOD0) + OFS_CH_STRIDE*n)) rdata = 32'(per_q[n]);
            if (ofs == 8'(int'(OFS_DUTY0) + OFS_CH_STRIDE*n))   rdata = 32'(duty_q[n]);
        end
    end

    // Bus handshake, registers and interrupt output
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            irq_q    <= 1'b0;
            ctrl_q   <= '0;
            status_q <= '0;
            mask_q   <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                per_q[n]  <= '0;
                duty_q[n] <= '0;
            end
        end else begin
            ack_q    <= acc;
            dat_q    <= (acc && !wbs_we_i) ? rdata : 32'h0;
            irq_q    <= |(status_q & mask_q);
            ctrl_q   <= ctrl_d;
            status_q <= status_d;
            mask_q   <= mask_d;
            for (int n = 0; n < NUM_CH; n++) begin
                per_q[n]  <= per_d[n];
                duty_q[n] <= duty_d[n];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pwm_channel #(.CNT_W(CNT_W)) u_ch (
            .clk    (wb_clk_i),
            .rst    (wb_rst_i),
            .en     (ctrl_q[g]),
            .period (per_d[g]),
            .duty   (duty_d[g]),
            .pwm    (pwm_o[g]),
            .oeb    (io_oeb[g]),
            .wrap   (wrap[g])
        );
    end

endmodule
